decode_stage: RTL and testbench
===============================

// Module: decode_stage
// PURPOSE
//  Registered, back-pressured instruction decode stage between fetch and execute.
//  Splits each 16-bit instruction word into group, operator, register, immediate and flag fields.
//  Assembles SPECIAL_LONG instructions from their LONG_WORDS extension words.
//  Pre-computes RJMP targets and supports pipeline flush.
// PARAMETERS
//  PC_W        16  program-counter width; also width of in_pc, out_pc and out_jump_target
//  LONG_WORDS  1   extension words following a SPECIAL_LONG opcode word (1..3)
// PORTS
//  clk              in   1               clock (rising edge)
//  reset            in   1               synchronous, active-high reset
//  flush            in   1               synchronous pipeline flush
//  in_word          in   16              instruction or extension word from fetch
//  in_pc            in   PC_W            address of in_word
//  in_valid         in   1               in_word/in_pc valid
//  in_ready         out  1               stage accepts in_word this cycle
//  out_valid        out  1               decoded instruction present
//  out_ready        in   1               execute consumes the decoded instruction
//  out_group        out  4               GROUP_* code
//  out_operator     out  4               word[15:12]
//  out_rg1          out  3               word[0] ? word[7:5] : word[3:1]
//  out_rg2          out  3               word[10:8]
//  out_val          out  8               word[11:4]
//  out_flags        out  8               word[15:8]
//  out_rel_addr     out  10              word[11:2]
//  out_jump_target  out  PC_W            pc + sign-extended out_rel_addr
//  out_ext          out  16*LONG_WORDS   extension words; word k in bits [16k+15:16k]
//  out_long         out  1               instruction is SPECIAL_LONG
//  out_pc           out  PC_W            address of the opcode word
// BEHAVIOUR
//  - Clock and reset: one clock, clk. reset is synchronous, active-high.
//    * On reset, every output register is 0 and the FSM enters S_OP with ext_cnt=0.
//  - Group decode, matching on word[4:0]:
//    * ????0 -> CRVMATH; ???01 -> RJMP; 00111 -> CRRMATH; 01111 -> CRSMATH.
//    * 10111 -> WRRMATH_MEM if word[15:12] is 1000, 1001, 1010, 1100, 1101 or 1110; otherwise WRRMATH.
//    * 11111 -> WRSMATH_STACK if word[15:13]=111; otherwise WRSMATH.
//    * 00011 -> SFLAG; 10011 -> UFLAG.
//    * 11011 -> SPECIAL_LONG if word[15:14]=11; otherwise SPECIAL. Any other code -> SPECIAL.
//  - Handshakes:
//    * can_load = !out_valid | out_ready.
//    * in_ready = !flush & (can_load | (state==S_EXT & ext_cnt != LONG_WORDS-1)).
//    * A word transfers when in_valid & in_ready.
//  - FSM S_OP (expecting an opcode word):
//    * A non-long word loads the output register; out_valid=1 the next cycle (latency 1).
//    * A SPECIAL_LONG word latches its fields and pc into a pending register, sets ext_cnt=0 and goes to S_EXT.
//  - FSM S_EXT (collecting extension words):
//    * Each accepted word is written to slot ext_cnt, then ext_cnt increments.
//    * The last word (ext_cnt==LONG_WORDS-1) loads pending fields plus out_ext into the output register.
//      It sets out_long=1 and returns to S_OP. Its in_pc is ignored.
//  - Output register behaviour:
//    * out_ext and out_long are 0 for non-long instructions.
//    * All out_* are held stable while out_valid & !out_ready.
//    * If out_ready and a new load occur in the same cycle, the new value replaces the old one and out_valid stays 1.
//    * If out_ready is high and nothing loads, out_valid drops to 0.
//  - Jump target arithmetic:
//    * out_jump_target = in_pc + {{(PC_W-10){rel[9]}}, rel}, modulo 2^PC_W, with no overflow flag.
//    * It is computed for every group and is meaningful only for RJMP.
//  - Flush:
//    * Next cycle: out_valid=0, state=S_OP, ext_cnt=0, pending cleared.
//    * The input in the flush cycle is not accepted (in_ready=0).
//    * Flush mid-long discards the partial instruction.
//  - Reset has priority over flush. Both have priority over handshakes.
//  - in_valid may drop between opcode and extension words. S_EXT waits indefinitely.
// STRUCTURE
//  - GROUP_* codes stay in the shared cpu_data.v include; add LONG_WORDS_MAX=3 there.
//  - Sub-module instr_fields: purely combinational word -> {group, operator, rg1, rg2, val, flags, rel_addr}.
//  - Top level holds the FSM, the pending/extension registers, the output register and the target adder.
// TESTING
//  1. Short decode: 16'h3A52 at pc 0x0010, out_ready=1
//     -> next cycle CRVMATH, operator=3, val=8'hA5, rg1=1, rg2=2, out_pc=0x0010, out_long=0.
//  2. RJMP wrap: 16'h0FFD at pc 0x0100 -> rel_addr=10'h3FF, target=0x00FF.
//     Same word at pc 0x0000 -> target=0xFFFF.
//  3. Long (LONG_WORDS=1): 16'hC01B at pc 0x0020, then 16'hBEEF
//     -> one output, SPECIAL_LONG, out_ext=16'hBEEF, out_long=1, out_pc=0x0020.
//  4. Back-pressure: out_ready=0 with three words offered
//     -> first output held stable, in_ready=0. Raise out_ready -> outputs stream one per cycle, no loss or duplication.
//  5. Flush during S_EXT after 16'hC01B (LONG_WORDS=2, one ext word taken)
//     -> out_valid stays 0, state S_OP.
//     A subsequent 16'h3A52 decodes as CRVMATH, not as an extension.
//  6. Reset asserted with out_valid=1 in S_EXT
//     -> next cycle all outputs 0, in_ready=1, and the next opcode decodes normally.

Source files
------------

// File: rtl/decode_stage_pkg.sv
// -----------------------------------------------------------------------------
// decode_stage_pkg
//   Shared definitions for the instruction decode stage: instruction group
//   codes, FSM state type, the decoded-field bundle and the group classifier.
//   Imported by decode_stage and decode_stage_instr_fields.
// -----------------------------------------------------------------------------
package decode_stage_pkg;

    // Instruction group codes presented on out_group.
    localparam logic [3:0] GROUP_CRVMATH       = 4'd0;
    localparam logic [3:0] GROUP_RJMP          = 4'd1;
    localparam logic [3:0] GROUP_CRRMATH       = 4'd2;
    localparam logic [3:0] GROUP_CRSMATH       = 4'd3;
    localparam logic [3:0] GROUP_WRRMATH       = 4'd4;
    localparam logic [3:0] GROUP_WRRMATH_MEM   = 4'd5;
    localparam logic [3:0] GROUP_WRSMATH       = 4'd6;
    localparam logic [3:0] GROUP_WRSMATH_STACK = 4'd7;
    localparam logic [3:0] GROUP_SFLAG         = 4'd8;
    localparam logic [3:0] GROUP_UFLAG         = 4'd9;
    localparam logic [3:0] GROUP_SPECIAL       = 4'd10;
    localparam logic [3:0] GROUP_SPECIAL_LONG  = 4'd11;

    // Largest supported number of extension words behind a SPECIAL_LONG word.
    localparam int LONG_WORDS_MAX = 3;

    // Width of the extension-word counter; covers slots 0..LONG_WORDS_MAX-1.
    localparam int EXT_CNT_W = 2;

    typedef enum logic {
        S_OP  = 1'b0,   // expecting an opcode word
        S_EXT = 1'b1    // collecting extension words of a SPECIAL_LONG
    } state_e;

    // All fields extracted from one 16-bit opcode word.
    typedef struct packed {
        logic [3:0] group;
        logic [3:0] operator;
        logic [2:0] rg1;
        logic [2:0] rg2;
        logic [7:0] val;
        logic [7:0] flags;
        logic [9:0] rel_addr;
    } fields_t;

    // Classify an opcode word into its instruction group from word[4:0],
    // refined by the top bits for the MEM / STACK / LONG variants.
    function automatic logic [3:0] decode_group(input logic [15:0] word);
        logic [3:0] grp;
        grp = GROUP_SPECIAL;
        casez (word[4:0])
            5'b????0: grp = GROUP_CRVMATH;
            5'b???01: grp = GROUP_RJMP;
            5'b00111: grp = GROUP_CRRMATH;
            5'b01111: grp = GROUP_CRSMATH;
            5'b10111: begin
                case (word[15:12])
                    4'h8, 4'h9, 4'hA, 4'hC, 4'hD, 4'hE: grp = GROUP_WRRMATH_MEM;
                    default:                            grp = GROUP_WRRMATH;
                endcase
            end
            5'b11111: grp = (word[15:13] == 3'b111) ? GROUP_WRSMATH_STACK : GROUP_WRSMATH;
            5'b00011: grp = GROUP_SFLAG;
            5'b10011: grp = GROUP_UFLAG;
            5'b11011: grp = (word[15:14] == 2'b11) ? GROUP_SPECIAL_LONG : GROUP_SPECIAL;
            default:  grp = GROUP_SPECIAL;
        endcase
        return grp;
    endfunction

endpackage

// File: rtl/decode_stage_instr_fields.sv
// -----------------------------------------------------------------------------
// decode_stage_instr_fields
//   Purely combinational split of a 16-bit instruction word into its fields.
//   Ports:
//     word      in   16  instruction word
//     group     out  4   GROUP_* code
//     operator  out  4   word[15:12]
//     rg1       out  3   word[0] ? word[7:5] : word[3:1]
//     rg2       out  3   word[10:8]
//     val       out  8   word[11:4]
//     flags     out  8   word[15:8]
//     rel_addr  out  10  word[11:2]
// -----------------------------------------------------------------------------
module decode_stage_instr_fields
    import decode_stage_pkg::*;
(
    input  logic [15:0] word,
    output logic [3:0]  group,
    output logic [3:0]  operator,
    output logic [2:0]  rg1,
    output logic [2:0]  rg2,
    output logic [7:0]  val,
    output logic [7:0]  flags,
    output logic [9:0]  rel_addr
);

    assign group    = decode_group(word);
    assign operator = word[15:12];
    // Bit 0 selects which nibble carries the first register operand.
    assign rg1      = word[0] ? word[7:5] : word[3:1];
    assign rg2      = word[10:8];
    assign val      = word[11:4];
    assign flags    = word[15:8];
    assign rel_addr = word[11:2];

endmodule

// File: rtl/decode_stage.sv
// -----------------------------------------------------------------------------
// decode_stage
//   Registered, back-pressured decode stage between fetch and execute.
//   Decodes each opcode word, assembles SPECIAL_LONG instructions from their
//   extension words, pre-computes relative jump targets and supports flush.
//   Ports:
//     clk, reset          clock, synchronous active-high reset
//     flush               synchronous pipeline flush
//     in_word/in_pc       word from fetch and its address
//     in_valid/in_ready   fetch handshake
//     out_valid/out_ready execute handshake
//     out_group .. out_rel_addr   decoded fields of the opcode word
//     out_jump_target     opcode pc + sign-extended rel_addr (mod 2^PC_W)
//     out_ext             extension words, word k in bits [16k+15:16k]
//     out_long            instruction is SPECIAL_LONG
//     out_pc              address of the opcode word
//   PC_W must exceed 10; LONG_WORDS must be 1..LONG_WORDS_MAX.
// -----------------------------------------------------------------------------
module decode_stage
    import decode_stage_pkg::*;
#(
    parameter int PC_W       = 16,
    parameter int LONG_WORDS = 1
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    flush,
    input  logic [15:0]             in_word,
    input  logic [PC_W-1:0]         in_pc,
    input  logic                    in_valid,
    output logic                    in_ready,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [3:0]              out_group,
    output logic [3:0]              out_operator,
    output logic [2:0]              out_rg1,
    output logic [2:0]              out_rg2,
    output logic [7:0]              out_val,
    output logic [7:0]              out_flags,
    output logic [9:0]              out_rel_addr,
    output logic [PC_W-1:0]         out_jump_target,
    output logic [16*LONG_WORDS-1:0] out_ext,
    output logic                    out_long,
    output logic [PC_W-1:0]         out_pc
);

    localparam logic [EXT_CNT_W-1:0] LAST_SLOT = EXT_CNT_W'(LONG_WORDS - 1);

    // ------------------------------------------------------------------
    // Field decode of the incoming word
    // ------------------------------------------------------------------
    logic [3:0] dec_group;
    logic [3:0] dec_operator;
    logic [2:0] dec_rg1;
    logic [2:0] dec_rg2;
    logic [7:0] dec_val;
    logic [7:0] dec_flags;
    logic [9:0] dec_rel_addr;
    fields_t    dec;

    decode_stage_instr_fields u_fields (
        .word     (in_word),
        .group    (dec_group),
        .operator (dec_operator),
        .rg1      (dec_rg1),
        .rg2      (dec_rg2),
        .val      (dec_val),
        .flags    (dec_flags),
        .rel_addr (dec_rel_addr)
    );

    assign dec = '{group:    dec_group,
                   operator: dec_operator,
                   rg1:      dec_rg1,
                   rg2:      dec_rg2,
                   val:      dec_val,
                   flags:    dec_flags,
                   rel_addr: dec_rel_addr};

    // Jump target adder; wraps modulo 2^PC_W. Only the opcode word's pc
    // feeds it, so a long instruction's target is captured at opcode time.
    logic [PC_W-1:0] rel_sext;
    logic [PC_W-1:0] target_sum;

    assign rel_sext   = {{(PC_W-10){dec_rel_addr[9]}}, dec_rel_addr};
    assign target_sum = in_pc + rel_sext;

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    state_e                          state_q, state_d;
    logic [EXT_CNT_W-1:0]            ext_cnt_q, ext_cnt_d;
    fields_t                         pend_q, pend_d;
    logic [PC_W-1:0]                 pend_pc_q, pend_pc_d;
    logic [PC_W-1:0]                 pend_target_q, pend_target_d;
    logic [LONG_WORDS-1:0][15:0]     ext_q, ext_d;

    logic                            out_valid_q, out_valid_d;
    fields_t                         out_fields_q, out_fields_d;
    logic [PC_W-1:0]                 out_target_q, out_target_d;
    logic [LONG_WORDS-1:0][15:0]     out_ext_q, out_ext_d;
    logic                            out_long_q, out_long_d;
    logic [PC_W-1:0]                 out_pc_q, out_pc_d;

    // ------------------------------------------------------------------
    // Handshake
    // ------------------------------------------------------------------
    logic can_load;
    logic ext_more;
    logic in_ready_int;
    logic xfer;

    assign can_load     = !out_valid_q || out_ready;
    // Non-final extension words never touch the output register, so they
    // may be taken even while execute is stalling.
    assign ext_more     = (state_q == S_EXT) && (ext_cnt_q != LAST_SLOT);
    assign in_ready_int = !flush && (can_load || ext_more);
    assign xfer         = in_valid && in_ready_int;
    assign in_ready     = in_ready_int;

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_d       = state_q;
        ext_cnt_d     = ext_cnt_q;
        pend_d        = pend_q;
        pend_pc_d     = pend_pc_q;
        pend_target_d = pend_target_q;
        ext_d         = ext_q;

        // A consumed output drops unless something reloads it below.
        out_valid_d   = out_valid_q && !out_ready;
        out_fields_d  = out_fields_q;
        out_target_d  = out_target_q;
        out_ext_d     = out_ext_q;
        out_long_d    = out_long_q;
        out_pc_d      = out_pc_q;

        if (flush) begin
            // Discard any partially assembled long instruction.
            out_valid_d   = 1'b0;
            state_d       = S_OP;
            ext_cnt_d     = '0;
            pend_d        = '0;
            pend_pc_d     = '0;
            pend_target_d = '0;
            ext_d         = '0;
        end else if (xfer) begin
            case (state_q)
                S_OP: begin
                    if (dec_group == GROUP_SPECIAL_LONG) begin
                        pend_d        = dec;
                        pend_pc_d     = in_pc;
                        pend_target_d = target_sum;
                        ext_cnt_d     = '0;
                        state_d       = S_EXT;
                    end else begin
                        out_valid_d  = 1'b1;
                        out_fields_d = dec;
                        out_target_d = target_sum;
                        out_ext_d    = '0;
                        out_long_d   = 1'b0;
                        out_pc_d     = in_pc;
                    end
                end
                S_EXT: begin
                    for (int k = 0; k < LONG_WORDS; k++) begin
                        if (ext_cnt_q == EXT_CNT_W'(k)) begin
                            ext_d[k] = in_word;
                        end
                    end
                    if (ext_cnt_q == LAST_SLOT) begin
                        // ext_d already holds the final word in its slot.
                        out_valid_d  = 1'b1;
                        out_fields_d = pend_q;
                        out_target_d = pend_target_q;
                        out_ext_d    = ext_d;
                        out_long_d   = 1'b1;
                        out_pc_d     = pend_pc_q;
                        state_d      = S_OP;
                        ext_cnt_d    = '0;
                    end else begin
                        ext_cnt_d = ext_cnt_q + 1'b1;
                    end
                end
                default: begin
                    state_d = S_OP;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= S_OP;
            ext_cnt_q     <= '0;
            pend_q        <= '0;
            pend_pc_q     <= '0;
            pend_target_q <= '0;
            ext_q         <= '0;
            out_valid_q   <= 1'b0;
            out_fields_q  <= '0;
            out_target_q  <= '0;
            out_ext_q     <= '0;
            out_long_q    <= 1'b0;
            out_pc_q      <= '0;
        end else begin
            state_q       <= state_d;
            ext_cnt_q     <= ext_cnt_d;
            pend_q        <= pend_d;
            pend_pc_q     <= pend_pc_d;
            pend_target_q <= pend_target_d;
            ext_q         <= ext_d;
            out_valid_q   <= out_valid_d;
            out_fields_q  <= out_fields_d;
            out_target_q  <= out_target_d;
            out_ext_q     <= out_ext_d;
            out_long_q    <= out_long_d;
            out_pc_q      <= out_pc_d;
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign out_valid       = out_valid_q;
    assign out_group       = out_fields_q.group;
    assign out_operator    = out_fields_q.operator;
    assign out_rg1         = out_fields_q.rg1;
    assign out_rg2         = out_fields_q.rg2;
    assign out_val         = out_fields_q.val;
    assign out_flags       = out_fields_q.flags;
    assign out_rel_addr    = out_fields_q.rel_addr;
    assign out_jump_target = out_target_q;
    assign out_ext         = out_ext_q;
    assign out_long        = out_long_q;
    assign out_pc          = out_pc_q;

endmodule

// File: tb/tb_decode_stage.sv
// -----------------------------------------------------------------------------
// tb_decode_stage
//   Two decode_stage instances: index 0 with LONG_WORDS=1, index 1 with
//   LONG_WORDS=2. Expected transactions are queued as stimulus is issued and
//   a monitor pops/compares each time an instance hands an output to execute.
// -----------------------------------------------------------------------------
module tb_decode_stage;
    import decode_stage_pkg::*;

    typedef struct {
        int          d;
        logic [3:0]  grp;
        logic [3:0]  opr;
        logic [2:0]  rg1;
        logic [2:0]  rg2;
        logic [7:0]  val;
        logic [7:0]  flags;
        logic [9:0]  rel;
        logic [15:0] tgt;
        logic [47:0] ext;
        logic        lng;
        logic [15:0] pc;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset;
    logic        flush           [2];
    logic [15:0] in_word         [2];
    logic [15:0] in_pc           [2];
    logic        in_valid        [2];
    logic        in_ready        [2];
    logic        out_valid       [2];
    logic        out_ready       [2];
    logic [3:0]  out_group       [2];
    logic [3:0]  out_operator    [2];
    logic [2:0]  out_rg1         [2];
    logic [2:0]  out_rg2         [2];
    logic [7:0]  out_val         [2];
    logic [7:0]  out_flags       [2];
    logic [9:0]  out_rel_addr    [2];
    logic [15:0] out_jump_target [2];
    logic [47:0] out_ext         [2];
    logic        out_long        [2];
    logic [15:0] out_pc          [2];

    exp_t sb[$];
    exp_t e_mon;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    for (genvar gi = 0; gi < 2; gi++) begin : g_dut
        logic [16*(gi+1)-1:0] ext_w;
        decode_stage #(.PC_W(16), .LONG_WORDS(gi + 1)) u_dut (
            .clk             (clk),
            .reset           (reset),
            .flush           (flush[gi]),
            .in_word         (in_word[gi]),
            .in_pc           (in_pc[gi]),
            .in_valid        (in_valid[gi]),
            .in_ready        (in_ready[gi]),
            .out_valid       (out_valid[gi]),
            .out_ready       (out_ready[gi]),
            .out_group       (out_group[gi]),
            .out_operator    (out_operator[gi]),
            .out_rg1         (out_rg1[gi]),
            .out_rg2         (out_rg2[gi]),
            .out_val         (out_val[gi]),
            .out_flags       (out_flags[gi]),
            .out_rel_addr    (out_rel_addr[gi]),
            .out_jump_target (out_jump_target[gi]),
            .out_ext         (ext_w),
            .out_long        (out_long[gi]),
            .out_pc          (out_pc[gi])
        );
        assign out_ext[gi] = 48'(ext_w);
    end

    task automatic chk(input string name, input logic [47:0] act, input logic [47:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    function automatic exp_t mk(input int d, input logic [3:0] grp, input logic [3:0] opr,
                                input logic [2:0] rg1, input logic [2:0] rg2,
                                input logic [7:0] val, input logic [7:0] flags,
                                input logic [9:0] rel, input logic [15:0] tgt,
                                input logic [47:0] ext, input logic lng, input logic [15:0] pc);
        exp_t e;
        e.d = d; e.grp = grp; e.opr = opr; e.rg1 = rg1; e.rg2 = rg2; e.val = val;
        e.flags = flags; e.rel = rel; e.tgt = tgt; e.ext = ext; e.lng = lng; e.pc = pc;
        return e;
    endfunction

    // Offer one word and wait (bounded) until the DUT takes it.
    // Called and returns at 1 time unit after a rising edge.
    task automatic send(input int d, input logic [15:0] w, input logic [15:0] pc);
        bit acc;
        acc = 1'b0;
        in_word[d]  = w;
        in_pc[d]    = pc;
        in_valid[d] = 1'b1;
        for (int n = 0; n < 50 && !acc; n++) begin
            @(negedge clk);
            acc = in_ready[d];
            @(posedge clk);
            #1;
        end
        in_valid[d] = 1'b0;
        if (!acc) begin
            checks++;
            errors++;
            $display("FAIL send_timeout: dut%0d word %h not accepted, expected acceptance", d, w);
        end
    endtask

    task automatic issue(input int d, input logic [15:0] w, input logic [15:0] pc, input exp_t e);
        sb.push_back(e);
        send(d, w, pc);
    endtask

    task automatic drain();
        for (int n = 0; n < 20 && sb.size() != 0; n++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic pulse_reset();
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    task automatic chk_reset(input int d);
        chk("rst_out_valid",   out_valid[d],       1'b0);
        chk("rst_in_ready",    in_ready[d],        1'b1);
        chk("rst_out_group",   out_group[d],       4'h0);
        chk("rst_out_operator", out_operator[d],   4'h0);
        chk("rst_out_rg1",     out_rg1[d],         3'h0);
        chk("rst_out_val",     out_val[d],         8'h0);
        chk("rst_out_flags",   out_flags[d],       8'h0);
        chk("rst_out_rel",     out_rel_addr[d],    10'h0);
        chk("rst_out_target",  out_jump_target[d], 16'h0);
        chk("rst_out_ext",     out_ext[d],         48'h0);
        chk("rst_out_long",    out_long[d],        1'b0);
        chk("rst_out_pc",      out_pc[d],          16'h0);
    endtask

    // Monitor: compare every output execute consumes against the queue head.
    always @(negedge clk) begin
        for (int d = 0; d < 2; d++) begin
            if (!reset && out_valid[d] && out_ready[d]) begin
                if (sb.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_output: dut%0d pc %h group %0d, expected no output", d, out_pc[d], out_group[d]);
                end else begin
                    e_mon = sb.pop_front();
                    $display("txn dut%0d pc=%h group=%0d op=%h rg1=%0d rg2=%0d val=%h flags=%h rel=%h tgt=%h ext=%h long=%0d",
                             d, out_pc[d], out_group[d], out_operator[d], out_rg1[d], out_rg2[d],
                             out_val[d], out_flags[d], out_rel_addr[d], out_jump_target[d], out_ext[d], out_long[d]);
                    chk("mon_dut",    48'(d),             48'(e_mon.d));
                    chk("mon_group",  out_group[d],       e_mon.grp);
                    chk("mon_op",     out_operator[d],    e_mon.opr);
                    chk("mon_rg1",    out_rg1[d],         e_mon.rg1);
                    chk("mon_rg2",    out_rg2[d],         e_mon.rg2);
                    chk("mon_val",    out_val[d],         e_mon.val);
                    chk("mon_flags",  out_flags[d],       e_mon.flags);
                    chk("mon_rel",    out_rel_addr[d],    e_mon.rel);
                    chk("mon_target", out_jump_target[d], e_mon.tgt);
                    chk("mon_ext",    out_ext[d],         e_mon.ext);
                    chk("mon_long",   out_long[d],        e_mon.lng);
                    chk("mon_pc",     out_pc[d],          e_mon.pc);
                end
            end
        end
    end

    initial begin
        for (int d = 0; d < 2; d++) begin
            flush[d]     = 1'b0;
            in_word[d]   = 16'h0;
            in_pc[d]     = 16'h0;
            in_valid[d]  = 1'b0;
            out_ready[d] = 1'b1;
        end
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        chk_reset(0);

        // 1. Short decode, latency 1
        issue(0, 16'h3A52, 16'h0010,
              mk(0, GROUP_CRVMATH, 4'h3, 3'd1, 3'd2, 8'hA5, 8'h3A, 10'h294, 16'hFEA4, 48'h0, 1'b0, 16'h0010));
        chk("t1_latency_valid", out_valid[0], 1'b1);

        // 2. RJMP with negative offset, including wrap below zero
        issue(0, 16'h0FFD, 16'h0100,
              mk(0, GROUP_RJMP, 4'h0, 3'd7, 3'd7, 8'hFF, 8'h0F, 10'h3FF, 16'h00FF, 48'h0, 1'b0, 16'h0100));
        issue(0, 16'h0FFD, 16'h0000,
              mk(0, GROUP_RJMP, 4'h0, 3'd7, 3'd7, 8'hFF, 8'h0F, 10'h3FF, 16'hFFFF, 48'h0, 1'b0, 16'h0000));

        // Remaining groups, back to back
        issue(0, 16'h1263, 16'h0050, mk(0, GROUP_SFLAG,   4'h1, 3'd3, 3'd2, 8'h26, 8'h12, 10'h098, 16'h00E8, 48'h0, 1'b0, 16'h0050));
        issue(0, 16'h0013, 16'h0070, mk(0, GROUP_UFLAG,   4'h0, 3'd0, 3'd0, 8'h01, 8'h00, 10'h004, 16'h0074, 48'h0, 1'b0, 16'h0070));
        issue(0, 16'h0007, 16'h0060, mk(0, GROUP_CRRMATH, 4'h0, 3'd0, 3'd0, 8'h00, 8'h00, 10'h001, 16'h0061, 48'h0, 1'b0, 16'h0060));
        issue(0, 16'h000F, 16'h00A0, mk(0, GROUP_CRSMATH, 4'h0, 3'd0, 3'd0, 8'h00, 8'h00, 10'h003, 16'h00A3, 48'h0, 1'b0, 16'h00A0));
        issue(0, 16'h001F, 16'h00B0, mk(0, GROUP_WRSMATH, 4'h0, 3'd0, 3'd0, 8'h01, 8'h00, 10'h007, 16'h00B7, 48'h0, 1'b0, 16'h00B0));
        issue(0, 16'h401B, 16'h0080, mk(0, GROUP_SPECIAL, 4'h4, 3'd0, 3'd0, 8'h01, 8'h40, 10'h006, 16'h0086, 48'h0, 1'b0, 16'h0080));
        issue(0, 16'h000B, 16'h0090, mk(0, GROUP_SPECIAL, 4'h0, 3'd0, 3'd0, 8'h00, 8'h00, 10'h002, 16'h0092, 48'h0, 1'b0, 16'h0090));

        // 3. Long instruction, one extension word (its pc is ignored)
        sb.push_back(mk(0, GROUP_SPECIAL_LONG, 4'hC, 3'd0, 3'd0, 8'h01, 8'hC0, 10'h006, 16'h0026, 48'h0000_0000_BEEF, 1'b1, 16'h0020));
        send(0, 16'hC01B, 16'h0020);
        chk("t3_no_output_after_opcode", out_valid[0], 1'b0);
        send(0, 16'hBEEF, 16'h0999);
        chk("t3_output_after_ext", out_valid[0], 1'b1);
        drain();

        // 4. Back-pressure: three words offered while execute stalls
        out_ready[0] = 1'b0;
        fork
            begin
                issue(0, 16'h8017, 16'h0200, mk(0, GROUP_WRRMATH_MEM,   4'h8, 3'd0, 3'd0, 8'h01, 8'h80, 10'h005, 16'h0205, 48'h0, 1'b0, 16'h0200));
                issue(0, 16'hB017, 16'h0300, mk(0, GROUP_WRRMATH,       4'hB, 3'd0, 3'd0, 8'h01, 8'hB0, 10'h005, 16'h0305, 48'h0, 1'b0, 16'h0300));
                issue(0, 16'hE0FF, 16'h0400, mk(0, GROUP_WRSMATH_STACK, 4'hE, 3'd7, 3'd0, 8'h0F, 8'hE0, 10'h03F, 16'h043F, 48'h0, 1'b0, 16'h0400));
            end
            begin
                repeat (4) begin @(posedge clk); #1; end
                chk("t4_stall_valid",    out_valid[0], 1'b1);
                chk("t4_stall_in_ready", in_ready[0],  1'b0);
                chk("t4_stall_pc",       out_pc[0],    16'h0200);
                repeat (2) begin @(posedge clk); #1; end
                chk("t4_hold_pc",        out_pc[0],    16'h0200);
                chk("t4_hold_group",     out_group[0], GROUP_WRRMATH_MEM);
                chk("t4_hold_target",    out_jump_target[0], 16'h0205);
                out_ready[0] = 1'b1;
            end
        join
        drain();

        // 5. Flush mid-long on the two-extension-word instance
        send(1, 16'hC01B, 16'h0020);
        send(1, 16'h1111, 16'h0021);
        chk("t5_partial_no_output", out_valid[1], 1'b0);
        flush[1] = 1'b1;
        @(negedge clk);
        chk("t5_flush_in_ready", in_ready[1], 1'b0);
        @(posedge clk);
        #1;
        flush[1] = 1'b0;
        chk("t5_flush_valid", out_valid[1], 1'b0);
        issue(1, 16'h3A52, 16'h0010,
              mk(1, GROUP_CRVMATH, 4'h3, 3'd1, 3'd2, 8'hA5, 8'h3A, 10'h294, 16'hFEA4, 48'h0, 1'b0, 16'h0010));
        chk("t5_short_after_flush", out_valid[1], 1'b1);
        sb.push_back(mk(1, GROUP_SPECIAL_LONG, 4'hC, 3'd0, 3'd0, 8'h01, 8'hC0, 10'h006, 16'h0026, 48'h0000_2222_1111, 1'b1, 16'h0020));
        send(1, 16'hC01B, 16'h0020);
        send(1, 16'h1111, 16'h0021);
        send(1, 16'h2222, 16'h0022);
        drain();

        // 6. Reset with a held output, then reset while in S_EXT
        out_ready[0] = 1'b0;
        send(0, 16'h3A52, 16'h0010);
        chk("t6_held_valid", out_valid[0], 1'b1);
        pulse_reset();
        chk_reset(0);
        out_ready[0] = 1'b1;
        send(0, 16'hC01B, 16'h0020);
        pulse_reset();
        chk_reset(0);
        issue(0, 16'h3A52, 16'h0010,
              mk(0, GROUP_CRVMATH, 4'h3, 3'd1, 3'd2, 8'hA5, 8'h3A, 10'h294, 16'hFEA4, 48'h0, 1'b0, 16'h0010));
        drain();

        chk("scoreboard_empty", 48'(sb.size()), 48'h0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
